branch_predictor: RTL

//  Fetch-side gshare direction predictor plus direct-mapped BTB. Combinationally produces the
//  F_pred_taken / F_pht_idx / F_btb_hit / F_btb_target fields that enter the IF/ID register.

---
 rtl/branch_predictor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare direction predictor with direct-mapped BTB and stats counters
module branch_predictor #(
  parameter int PHT_IDX_W = 5,
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          F_PC,
  output logic                 F_pred_taken,
  output logic [PHT_IDX_W-1:0] F_pht_idx,
  output logic                 F_btb_hit,
  output logic [31:0]          F_btb_target,
  input  logic                 E_br_valid,
  input  logic                 E_jmp_valid,
  input  logic [31:0]          E_PC,
  input  logic [PHT_IDX_W-1:0] E_pht_idx,
  input  logic                 E_taken,
  input  logic [31:0]          E_target,
  input  logic                 E_mispredict,
  input  logic                 E_stall,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic [1:0]           pht_q [PHT_N];
  logic [1:0]           pht_d;
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;
  logic [BTB_N-1:0]     btb_valid_q;
  logic [TAG_W-1:0]     btb_tag_q [BTB_N];
  logic [31:0]          btb_tgt_q [BTB_N];
  logic [CNT_W-1:0]     br_count_q, br_count_d;
  logic [CNT_W-1:0]     mispred_q, mispred_d;

  logic                 upd, br_upd, btb_wr;
  logic [BTB_IDX_W-1:0] f_btb_idx, e_btb_idx;
  logic                 unused_pc_bits;

  // Word-aligned PCs: the low two bits never select anything.
  assign unused_pc_bits = ^{F_PC[1:0], E_PC[1:0]};

  // Fetch-side lookup reads only registered state, so a same-cycle write is not seen.
  assign f_btb_idx    = F_PC[BTB_IDX_W+1:2];
  assign F_pht_idx    = F_PC[PHT_IDX_W+1:2] ^ ghr_q;
  assign F_pred_taken = pht_q[F_pht_idx][1];
  assign F_btb_hit    = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == F_PC[31:BTB_IDX_W+2]);
  assign F_btb_target = F_btb_hit ? btb_tgt_q[f_btb_idx] : 32'h0;

  // A simultaneous branch+jump is treated as a jump: no direction training.
  assign upd       = (E_br_valid | E_jmp_valid) & ~E_stall;
  assign br_upd    = upd & E_br_valid & ~E_jmp_valid;
  assign btb_wr    = upd & (E_jmp_valid | E_taken);
  assign e_btb_idx = E_PC[BTB_IDX_W+1:2];

  // Saturating 2-bit counter step and non-speculative history shift.
  always_comb begin
    pht_d = pht_q[E_pht_idx];
    ghr_d = ghr_q;
    if (br_upd) begin
      if (E_taken && pht_d != 2'b11) begin
        pht_d = pht_d + 2'b01;
      end else if (!E_taken && pht_d != 2'b00) begin
        pht_d = pht_d - 2'b01;
      end
      ghr_d = {ghr_q[PHT_IDX_W-2:0], E_taken};
    end
  end

  // Statistics counters saturate at all-ones.
  always_comb begin
    br_count_d = br_count_q;
    mispred_d  = mispred_q;
    if (upd && br_count_q != {CNT_W{1'b1}}) begin
      br_count_d = br_count_q + 1'b1;
    end
    if (upd && E_mispredict && mispred_q != {CNT_W{1'b1}}) begin
      mispred_d = mispred_q + 1'b1;
    end
  end

  // PHT storage: weakly not-taken on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else if (br_upd) begin
      pht_q[E_pht_idx] <= pht_d;
    end
  end

  // BTB storage: last writer owns the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
      for (int i = 0; i < BTB_N; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= 32'h0;
      end
    end else if (btb_wr) begin
      btb_valid_q[e_btb_idx] <= 1'b1;
      btb_tag_q[e_btb_idx]   <= E_PC[31:BTB_IDX_W+2];
      btb_tgt_q[e_btb_idx]   <= E_target;
    end
  end

  // History and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q      <= '0;
      br_count_q <= '0;
      mispred_q  <= '0;
    end else begin
      ghr_q      <= ghr_d;
      br_count_q <= br_count_d;
      mispred_q  <= mispred_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_q;

endmodule
